// File: rtl/soc_pio_pkg.sv
// Shared constants and types for the double-buffered DDS control PIO.
package soc_pio_pkg;

    localparam int ADDR_CTRL        = 0;
    localparam int ADDR_STATUS      = 1;
    localparam int ADDR_SEL         = 2;
    localparam int ADDR_SET         = 3;
    localparam int ADDR_CLR         = 4;
    localparam int ADDR_ACTIVE      = 5;
    localparam int ADDR_SHADOW_BASE = 8;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_ABORT  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

endpackage

// File: rtl/soc_pio_dds_bank_if.sv
// Avalon-MM slave bus bundle for the PIO bank (zero wait states, write only via write_n).
interface soc_pio_dds_bank_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_pio_chan_reg.sv
// One channel: a software-visible shadow register and the active register it feeds on load.
module soc_pio_chan_reg #(
    parameter int             W         = 10,
    parameter logic [W-1:0]   RESET_VAL = '1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en_i,
    input  logic         set_en_i,
    input  logic         clr_en_i,
    input  logic [W-1:0] data_i,
    input  logic         load_i,
    output logic [W-1:0] shadow_o,
    output logic [W-1:0] active_o
);
    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] active_q, active_d;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i)       shadow_d = data_i;
        else if (set_en_i) shadow_d = shadow_q | data_i;
        else if (clr_en_i) shadow_d = shadow_q & ~data_i;
    end

    // Load takes the shadow as it stands before this edge's own update.
    assign active_d = load_i ? shadow_q : active_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= RESET_VAL;
            active_q <= RESET_VAL;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign shadow_o = shadow_q;
    assign active_o = active_q;
endmodule

// File: rtl/soc_pio_dds_bank.sv
// Multi-channel double-buffered output PIO; commit copies every shadow to its active
// register in one edge, immediately or on the next frame-sync rising edge.
module soc_pio_dds_bank
    import soc_pio_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int W         = 10,
    parameter int RESET_VAL = 1023,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    soc_pio_dds_bank_if.slave    bus,
    input  logic                 sync_in,
    output logic [NCH*W-1:0]     out_port,
    output logic                 update_pulse,
    output logic                 pending
);
    localparam logic [W-1:0] RST_W = W'(RESET_VAL);

    state_e      state_q, state_d;
    logic        mode_q, mode_d;
    logic [2:0]  sel_q, sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sync_prev_q;
    logic        pulse_q;
    logic        load;

    logic        wr_en, ctrl_wr, sel_wr, set_wr, clr_wr;
    logic        commit, abort, mode_wr, sync_rise;
    logic [W-1:0] shadow_w [NCH];
    logic [W-1:0] active_w [NCH];
    logic [W-1:0] rd_shadow, rd_active;
    logic [31:0]  rdata;
    logic         unused_wdata;

    assign wr_en   = bus.chipselect && !bus.write_n;
    assign ctrl_wr = wr_en && (bus.address == ADDR_W'(ADDR_CTRL));
    assign sel_wr  = wr_en && (bus.address == ADDR_W'(ADDR_SEL));
    assign set_wr  = wr_en && (bus.address == ADDR_W'(ADDR_SET));
    assign clr_wr  = wr_en && (bus.address == ADDR_W'(ADDR_CLR));
    assign commit  = ctrl_wr && bus.writedata[CTRL_COMMIT];
    assign abort   = ctrl_wr && bus.writedata[CTRL_ABORT];
    assign mode_wr = bus.writedata[CTRL_MODE];
    assign sync_rise = sync_in && !sync_prev_q;
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Arming only looks at sync from the next edge on, so a coincident edge never fires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (commit && !abort && mode_wr) state_d = ARMED;
            ARMED:   if (abort || sync_rise)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        case (state_q)
            IDLE:    load = commit && !abort && !mode_wr;
            ARMED:   load = sync_rise && !abort;
            default: load = 1'b0;
        endcase
    end

    always_comb begin
        mode_d = ctrl_wr ? mode_wr : mode_q;
        sel_d  = sel_wr ? bus.writedata[2:0] : sel_q;
        cnt_d  = load ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= 1'b0;
            sel_q       <= 3'd0;
            cnt_q       <= 8'd0;
            sync_prev_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            sync_prev_q <= sync_in;
            pulse_q     <= load;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic shadow_hit, sel_hit;
            assign shadow_hit = wr_en && (bus.address == ADDR_W'(ADDR_SHADOW_BASE + gi));
            assign sel_hit    = (sel_q == 3'(gi));

            soc_pio_chan_reg #(
                .W         (W),
                .RESET_VAL (RST_W)
            ) u_chan (
                .clk      (clk),
                .reset_n  (reset_n),
                .wr_en_i  (shadow_hit),
                .set_en_i (set_wr && sel_hit),
                .clr_en_i (clr_wr && sel_hit),
                .data_i   (bus.writedata[W-1:0]),
                .load_i   (load),
                .shadow_o (shadow_w[gi]),
                .active_o (active_w[gi])
            );

            assign out_port[gi*W +: W] = active_w[gi];
        end
    endgenerate

    // Unmatched addresses (SET/CLR, holes, shadows beyond NCH) fall through to zero.
    always_comb begin
        rd_shadow = '0;
        rd_active = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.address == ADDR_W'(ADDR_SHADOW_BASE + i)) rd_shadow = shadow_w[i];
            if (sel_q == 3'(i))                              rd_active = active_w[i];
        end
        rdata = '0;
        case (bus.address)
            ADDR_W'(ADDR_CTRL):   rdata[CTRL_MODE] = mode_q;
            ADDR_W'(ADDR_STATUS): rdata = {16'd0, cnt_q, 7'd0, state_q == ARMED};
            ADDR_W'(ADDR_SEL):    rdata[2:0] = sel_q;
            ADDR_W'(ADDR_ACTIVE): rdata[W-1:0] = rd_active;
            default:              rdata[W-1:0] = rd_shadow;
        endcase
    end

    assign bus.readdata = rdata;
    assign update_pulse = pulse_q;
    assign pending      = (state_q == ARMED);
endmodule

// File: tb/tb_soc_pio_dds_bank.sv
// Directed self-checking bench for soc_pio_dds_bank with NCH=4, W=10.
module tb_soc_pio_dds_bank;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_in = 1'b0;
    logic [39:0] out_port;
    logic        update_pulse;
    logic        pending;
    logic [31:0] rdv;
    int          errors = 0;
    int          checks = 0;

    soc_pio_dds_bank_if #(.ADDR_W(4)) bus ();

    soc_pio_dds_bank #(
        .NCH(4), .W(10), .RESET_VAL(1023), .ADDR_W(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .sync_in      (sync_in),
        .out_port     (out_port),
        .update_pulse (update_pulse),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] pk(logic [9:0] c0, logic [9:0] c1, logic [9:0] c2, logic [9:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    initial begin
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_out", out_port, pk(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF));
        chk("rst_pulse", update_pulse, 0);
        chk("rst_pending", pending, 0);
        rd(4'd1, rdv); chk("rst_status", rdv, 32'h0);
        rd(4'd8, rdv); chk("rst_shadow0", rdv, 32'h3FF);
        rd(4'd0, rdv); chk("rst_ctrl", rdv, 32'h0);

        // Immediate commit of ch1
        wr(4'd9, 32'h123);
        chk("pre_commit_out", out_port, pk(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF));
        wr(4'd0, 32'h1);
        chk("imm_out", out_port, pk(10'h3FF, 10'h123, 10'h3FF, 10'h3FF));
        chk("imm_pulse_hi", update_pulse, 1);
        tick();
        chk("imm_pulse_lo", update_pulse, 0);
        rd(4'd1, rdv); chk("imm_status", rdv, 32'h100);

        // Sync commit, sync already rising on the commit edge must not fire
        sync_in = 1'b1;
        wr(4'd0, 32'h3);
        chk("arm_pending", pending, 1);
        chk("arm_nopulse", update_pulse, 0);
        tick();
        chk("coinc_nofire", pending, 1);
        rd(4'd0, rdv); chk("ctrl_mode", rdv, 32'h2);
        wr(4'd8, 32'h055);
        chk("armed_out_hold", out_port, pk(10'h3FF, 10'h123, 10'h3FF, 10'h3FF));
        sync_in = 1'b0;
        tick();
        chk("armed_wait", pending, 1);
        sync_in = 1'b1;
        tick();
        chk("sync_out", out_port, pk(10'h055, 10'h123, 10'h3FF, 10'h3FF));
        chk("sync_pulse", update_pulse, 1);
        chk("sync_pend_lo", pending, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sync_hold_nopulse", update_pulse, 0);
        end
        rd(4'd1, rdv); chk("sync_status", rdv, 32'h200);
        sync_in = 1'b0;
        tick();

        // Abort, and COMMIT+ABORT from IDLE
        wr(4'd0, 32'h3);
        chk("arm2_pending", pending, 1);
        wr(4'd0, 32'h4);
        chk("abort_pending", pending, 0);
        sync_in = 1'b1;
        tick();
        tick();
        chk("abort_nopulse", update_pulse, 0);
        sync_in = 1'b0;
        rd(4'd1, rdv); chk("abort_status", rdv, 32'h200);
        wr(4'd0, 32'h7);
        chk("ca_pending", pending, 0);
        chk("ca_nopulse", update_pulse, 0);
        rd(4'd1, rdv); chk("ca_status", rdv, 32'h200);

        // SEL / SET / CLR / ACTIVE
        wr(4'd2, 32'h2);
        rd(4'd2, rdv); chk("sel_read", rdv, 32'h2);
        wr(4'd3, 32'h00F);
        wr(4'd4, 32'h003);
        rd(4'd10, rdv); chk("setclr_shadow2", rdv, 32'h3FC);
        rd(4'd5, rdv); chk("active_old", rdv, 32'h3FF);
        rd(4'd3, rdv); chk("set_reads0", rdv, 32'h0);
        wr(4'd0, 32'h1);
        rd(4'd5, rdv); chk("active_new", rdv, 32'h3FC);
        chk("setclr_out", out_port, pk(10'h055, 10'h123, 10'h3FC, 10'h3FF));
        rd(4'd1, rdv); chk("setclr_status", rdv, 32'h300);
        wr(4'd2, 32'h6);
        wr(4'd4, 32'h3FF);
        rd(4'd5, rdv); chk("sel6_active", rdv, 32'h0);
        rd(4'd12, rdv); chk("unmapped_12", rdv, 32'h0);
        rd(4'd7, rdv); chk("unmapped_7", rdv, 32'h0);

        // commit_cnt wrap: 3 loads so far, 253 more reach 256 -> 0
        for (int i = 0; i < 253; i++) wr(4'd0, 32'h1);
        rd(4'd1, rdv); chk("cnt_wrap", rdv, 32'h0);
        wr(4'd0, 32'h1);
        rd(4'd1, rdv); chk("cnt_after_wrap", rdv, 32'h100);

        // Asynchronous reset while ARMED
        wr(4'd0, 32'h3);
        chk("arm3_pending", pending, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstarm_pending", pending, 0);
        chk("rstarm_out", out_port, pk(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF));
        rd(4'd1, rdv); chk("rstarm_status", rdv, 32'h0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_pending", pending, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
